data_sram_arb: RTL and testbench
================================

// Module: data_sram_arb
// PURPOSE
//   Single-port data SRAM arbiter between the pipeline load/store path (EX-stage issue,
//   MEM-stage data return) and an auxiliary requester (debug/DMA) using valid/ready.
//   CPU has priority. Aux gets idle slots, plus a forced window after STARVE_LIMIT
//   blocked cycles, during which the CPU pipeline is stalled via stallreq.
//   Sits between EX/MEM and the data_sram_* pins.
// PARAMETERS
//   STARVE_LIMIT  8   consecutive blocked aux cycles before a forced aux window (>=1)
//   AUX_BURST     4   max aux grants per forced window (>=1)
//   CNT_W         4   width of starve/burst counters; must hold max(STARVE_LIMIT,AUX_BURST)
// PORTS
//   clk             in   1   clock
//   rst             in   1   synchronous active-high reset
//   cpu_req         in   1   EX-stage memory access this cycle (already qualified by stall/flush)
//   cpu_wen         in   4   byte write enables; 0 = load
//   cpu_addr        in   32  byte address
//   cpu_wdata       in   32  store data
//   stallreq_mem    out  1   stall request to pipeline control; CPU access not taken this cycle
//   aux_req         in   1   aux access valid
//   aux_ready       out  1   aux granted this cycle (handshake = aux_req & aux_ready)
//   aux_wen         in   4   aux byte write enables; 0 = read
//   aux_addr        in   32  aux byte address
//   aux_wdata       in   32  aux store data
//   aux_rvalid      out  1   aux read data valid
//   aux_rdata       out  32  aux read data
//   data_sram_en    out  1   SRAM enable
//   data_sram_wen   out  4   SRAM byte write enables
//   data_sram_addr  out  32  SRAM address
//   data_sram_wdata out  32  SRAM write data
//   data_sram_rdata in   32  SRAM read data, valid the cycle after a read enable
// BEHAVIOUR
//   Reset (rst=1 at posedge): state<=S_CPU, starve_cnt<=0, burst_cnt<=0, aux_rvalid<=0.
//     While rst=1, data_sram_en, aux_ready and stallreq_mem are forced to 0.
//   Grant (combinational, one access per cycle):
//     S_CPU: gnt_cpu=cpu_req; gnt_aux=aux_req & ~cpu_req.
//     S_AUX: gnt_aux=aux_req; gnt_cpu=cpu_req & ~aux_req.
//   aux_ready=gnt_aux. stallreq_mem=cpu_req & ~gnt_cpu.
//   SRAM mux: gnt_cpu -> cpu_*; gnt_aux -> aux_*; neither -> en=0, wen=0, addr/wdata=0.
//     data_sram_en=gnt_cpu|gnt_aux.
//   Read return: aux_rvalid<=gnt_aux & (aux_wen==0), so latency = 1 cycle.
//     aux_rdata=data_sram_rdata when aux_rvalid, else 0.
//     CPU load data returns on the same SRAM pins the following cycle and is consumed by MEM.
//     Aux and CPU returns never collide because only one access issues per cycle.
//     Back-to-back reads are pipelined with no bubble.
//   starve_cnt (S_CPU only):
//     +1 when aux_req & ~gnt_aux, saturating at STARVE_LIMIT.
//     Cleared on gnt_aux, when ~aux_req, and on entering S_AUX.
//   FSM:
//     S_CPU->S_AUX when aux_req & ~gnt_aux & starve_cnt==STARVE_LIMIT-1 (window starts next cycle);
//       burst_cnt<=0.
//     S_AUX: burst_cnt +1 per gnt_aux.
//       S_AUX->S_CPU when ~aux_req, or gnt_aux & burst_cnt==AUX_BURST-1.
//   Simultaneous cpu_req & aux_req: S_CPU -> CPU wins, aux waits with aux_ready=0;
//     S_AUX -> aux wins, stallreq_mem=1.
//   Aux inputs must be held stable while aux_req=1 & aux_ready=0; aux_req may drop without a grant.
//   Reset mid-read: pending aux_rvalid is dropped (0 next cycle); the read is not replayed.
// TESTING
//   1 cpu_req=1 load addr 0x100, aux idle -> en=1, wen=0, addr=0x100, stallreq_mem=0, aux_ready=0.
//   2 cpu_req=0, aux read 0x40, SRAM holds 0xDEADBEEF
//       -> aux_ready=1 at t; aux_rvalid=1, aux_rdata=0xDEADBEEF at t+1.
//   3 cpu_req & aux_req held high continuously (STARVE_LIMIT=8, AUX_BURST=4)
//       -> 8 CPU grants, then 4 aux grants with stallreq_mem=1, then CPU resumes; pattern repeats.
//   4 Forced window where aux_req drops after 2 grants
//       -> exit S_AUX next cycle, stallreq_mem=0 in the cycle aux_req=0.
//   5 Aux store wen=4'b0011 data 0x12345678 in idle slot
//       -> SRAM wen=0011, aux_rvalid stays 0; cpu read of same addr next cycle sees updated bytes.
//   6 rst asserted the cycle after an aux read grant -> aux_rvalid=0, state S_CPU, counters 0.

Source files
------------

// File: rtl/data_sram_arb_if.sv
// data_sram_arb_if: CPU/aux request, aux response and data SRAM pin bundle; slave = arbiter side, master = requester/SRAM side
interface data_sram_arb_if;
  logic        cpu_req;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        stallreq_mem;
  logic        aux_req;
  logic        aux_ready;
  logic [3:0]  aux_wen;
  logic [31:0] aux_addr;
  logic [31:0] aux_wdata;
  logic        aux_rvalid;
  logic [31:0] aux_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  modport slave (
    input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    output stallreq_mem,
    input  aux_req, aux_wen, aux_addr, aux_wdata,
    output aux_ready, aux_rvalid, aux_rdata,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );
  modport master (
    output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    input  stallreq_mem,
    output aux_req, aux_wen, aux_addr, aux_wdata,
    input  aux_ready, aux_rvalid, aux_rdata,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_arb.sv
// data_sram_arb: single-port data SRAM arbiter, CPU priority, aux gets idle slots plus forced windows after starvation; ports clk, rst, bus (cpu_*/aux_*/data_sram_*)
module data_sram_arb #(
  parameter int STARVE_LIMIT = 8,
  parameter int AUX_BURST    = 4,
  parameter int CNT_W        = 4
) (
  input logic            clk,
  input logic            rst,
  data_sram_arb_if.slave bus
);
  typedef enum logic {S_CPU, S_AUX} state_t;
  localparam logic [CNT_W-1:0] SL    = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] SL_M1 = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] AB_M1 = CNT_W'(AUX_BURST - 1);
  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt, burst_cnt, burst_nxt;
  logic             gnt_cpu, gnt_aux, starved, aux_rvalid;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_CPU;
      starve_cnt <= '0;
      burst_cnt  <= '0;
      aux_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      burst_cnt  <= burst_nxt;
      aux_rvalid <= gnt_aux & (bus.aux_wen == 4'b0);
    end
  end
  always_comb begin
    gnt_cpu    = ~rst & bus.cpu_req & ((state == S_CPU) | ~bus.aux_req);
    gnt_aux    = ~rst & bus.aux_req & ((state == S_AUX) | ~bus.cpu_req);
    starved    = bus.aux_req & ~gnt_aux;
    state_nxt  = state;
    starve_nxt = '0;
    burst_nxt  = burst_cnt;
    if (state == S_CPU) begin
      starve_nxt = ~starved ? '0 : (starve_cnt == SL) ? starve_cnt : starve_cnt + 1'b1;
      if (starved && starve_cnt == SL_M1) begin
        state_nxt  = S_AUX;
        starve_nxt = '0;
        burst_nxt  = '0;
      end
    end else begin
      burst_nxt = gnt_aux ? burst_cnt + 1'b1 : burst_cnt;
      if (!bus.aux_req || (gnt_aux && burst_cnt == AB_M1)) state_nxt = S_CPU;
    end
  end
  assign bus.stallreq_mem    = ~rst & bus.cpu_req & ~gnt_cpu;
  assign bus.aux_ready       = gnt_aux;
  assign bus.aux_rvalid      = aux_rvalid;
  assign bus.aux_rdata       = aux_rvalid ? bus.data_sram_rdata : 32'h0;
  assign bus.data_sram_en    = gnt_cpu | gnt_aux;
  assign bus.data_sram_wen   = gnt_cpu ? bus.cpu_wen   : gnt_aux ? bus.aux_wen   : 4'h0;
  assign bus.data_sram_addr  = gnt_cpu ? bus.cpu_addr  : gnt_aux ? bus.aux_addr  : 32'h0;
  assign bus.data_sram_wdata = gnt_cpu ? bus.cpu_wdata : gnt_aux ? bus.aux_wdata : 32'h0;
endmodule

// File: tb/tb_data_sram_arb.sv
// tb_data_sram_arb: directed bench with SRAM model, per-cycle behavioural arbiter model and literal checks
module tb_data_sram_arb;
  localparam int STARVE_LIMIT = 8;
  localparam int AUX_BURST    = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  data_sram_arb_if bus();
  data_sram_arb #(.STARVE_LIMIT(STARVE_LIMIT), .AUX_BURST(AUX_BURST), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (bus.data_sram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.data_sram_wen[b]) mem[bus.data_sram_addr[9:2]][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
      bus.data_sram_rdata <= mem[bus.data_sram_addr[9:2]];
    end
  end
  int n_cmp = 0;
  int n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  bit          armed = 1'b0;
  bit          win = 1'b0;
  int          blocked = 0;
  int          wgr = 0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic        e_cpu, e_aux;
  always @(negedge clk) begin
    if (armed) begin
      e_cpu = !rst && bus.cpu_req && (!win || !bus.aux_req);
      e_aux = !rst && bus.aux_req && (win || !bus.cpu_req);
      chk("stallreq_mem", 32'(bus.stallreq_mem), 32'(!rst && bus.cpu_req && !e_cpu));
      chk("aux_ready", 32'(bus.aux_ready), 32'(e_aux));
      chk("sram_en", 32'(bus.data_sram_en), 32'(e_cpu || e_aux));
      chk("sram_wen", 32'(bus.data_sram_wen), 32'(e_cpu ? bus.cpu_wen : e_aux ? bus.aux_wen : 4'h0));
      chk("sram_addr", bus.data_sram_addr, e_cpu ? bus.cpu_addr : e_aux ? bus.aux_addr : 32'h0);
      chk("sram_wdata", bus.data_sram_wdata, e_cpu ? bus.cpu_wdata : e_aux ? bus.aux_wdata : 32'h0);
      chk("aux_rvalid", 32'(bus.aux_rvalid), 32'(m_rvalid));
      chk("aux_rdata", bus.aux_rdata, m_rvalid ? m_rdata : 32'h0);
      if (rst) begin
        win = 1'b0;
        blocked = 0;
        wgr = 0;
        m_rvalid = 1'b0;
      end else begin
        m_rvalid = e_aux && bus.aux_wen == 4'h0;
        m_rdata  = mem[bus.aux_addr[9:2]];
        if (!win) begin
          blocked = (bus.aux_req && !e_aux) ? blocked + 1 : 0;
          if (blocked == STARVE_LIMIT) begin
            win = 1'b1;
            blocked = 0;
            wgr = 0;
          end
        end else begin
          wgr += int'(e_aux);
          if (!bus.aux_req || wgr == AUX_BURST) win = 1'b0;
        end
      end
    end
  end
  task automatic cyc(input logic cr, input logic [3:0] cw, input logic [31:0] ca, input logic [31:0] cd,
                     input logic ar, input logic [3:0] aw, input logic [31:0] aa, input logic [31:0] ad);
    @(posedge clk);
    #1;
    bus.cpu_req = cr;
    bus.cpu_wen = cw;
    bus.cpu_addr = ca;
    bus.cpu_wdata = cd;
    bus.aux_req = ar;
    bus.aux_wen = aw;
    bus.aux_addr = aa;
    bus.aux_wdata = ad;
  endtask
  task automatic smp;
    @(negedge clk);
    #1;
  endtask
  logic [23:0] sh, rh;
  logic [9:0]  h4;
  logic [8:0]  h6;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h01010101 * i;
    mem['h40 >> 2] = 32'hDEADBEEF;
    mem['h80 >> 2] = 32'hAABBCCDD;
    bus.cpu_req = 0; bus.cpu_wen = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.aux_req = 0; bus.aux_wen = 0; bus.aux_addr = 0; bus.aux_wdata = 0;
    bus.data_sram_rdata = 0;
    @(posedge clk);
    armed = 1'b1;
    cyc(1, 0, 'h100, 0, 1, 0, 'h40, 0);
    smp;
    chk("rst_en", 32'(bus.data_sram_en), 0);
    chk("rst_stall", 32'(bus.stallreq_mem), 0);
    chk("rst_ready", 32'(bus.aux_ready), 0);
    chk("rst_rvalid", 32'(bus.aux_rvalid), 0);
    cyc(1, 0, 'h100, 0, 0, 0, 0, 0);
    rst = 1'b0;
    smp;
    chk("t1_en", 32'(bus.data_sram_en), 1);
    chk("t1_wen", 32'(bus.data_sram_wen), 0);
    chk("t1_addr", bus.data_sram_addr, 32'h100);
    chk("t1_stall", 32'(bus.stallreq_mem), 0);
    chk("t1_ready", 32'(bus.aux_ready), 0);
    cyc(0, 0, 0, 0, 1, 0, 'h40, 0);
    smp;
    chk("t2_ready", 32'(bus.aux_ready), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    smp;
    chk("t2_rvalid", 32'(bus.aux_rvalid), 1);
    chk("t2_rdata", bus.aux_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 24; i++) begin
      cyc(1, 0, 'h200, 0, 1, 0, 'h44, 0);
      smp;
      sh[i] = bus.stallreq_mem;
      rh[i] = bus.aux_ready;
    end
    chk("t3_stall_pattern", 32'(sh), 32'hF00F00);
    chk("t3_ready_pattern", 32'(rh), 32'hF00F00);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 'h200, 0, 1, 0, 'h44, 0);
      smp;
      h4[i] = bus.stallreq_mem;
    end
    chk("t4_stall_pattern", 32'(h4), 32'h300);
    cyc(1, 0, 'h204, 0, 0, 0, 0, 0);
    smp;
    chk("t4_drop_stall", 32'(bus.stallreq_mem), 0);
    chk("t4_drop_addr", bus.data_sram_addr, 32'h204);
    cyc(1, 0, 'h204, 0, 1, 0, 'h44, 0);
    smp;
    chk("t4_exit_stall", 32'(bus.stallreq_mem), 0);
    chk("t4_exit_ready", 32'(bus.aux_ready), 0);
    cyc(0, 0, 0, 0, 1, 4'b0011, 'h80, 'h12345678);
    smp;
    chk("t5_wen", 32'(bus.data_sram_wen), 32'h3);
    chk("t5_wdata", bus.data_sram_wdata, 32'h12345678);
    chk("t5_ready", 32'(bus.aux_ready), 1);
    cyc(1, 0, 'h80, 0, 0, 0, 0, 0);
    smp;
    chk("t5_rvalid", 32'(bus.aux_rvalid), 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    smp;
    chk("t5_rdata", bus.data_sram_rdata, 32'hAABB5678);
    chk("t5_rvalid2", 32'(bus.aux_rvalid), 0);
    cyc(0, 0, 0, 0, 1, 0, 'h40, 0);
    smp;
    chk("t6_ready", 32'(bus.aux_ready), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    smp;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    smp;
    chk("t6_rvalid_dropped", 32'(bus.aux_rvalid), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 'h300, 0, 1, 0, 'h48, 0);
      rst = 1'b0;
      smp;
    end
    cyc(1, 0, 'h300, 0, 1, 0, 'h48, 0);
    rst = 1'b1;
    smp;
    for (int i = 0; i < 9; i++) begin
      cyc(1, 0, 'h300, 0, 1, 0, 'h48, 0);
      rst = 1'b0;
      smp;
      h6[i] = bus.stallreq_mem;
    end
    chk("t6_counter_cleared", 32'(h6), 32'h100);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    smp;
    smp;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
